// File: rtl/interleaver_prime_sequencer.sv
// Block interleaver: fills N symbols, then drains them in prime-stride order.
// Forward permutes on read, reverse permutes on write; one register bank.
module interleaver_prime_sequencer #(
  parameter int BITS = 8,
  parameter int N    = 10,
  parameter int P    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int AW = $clog2(N) + 1;
  localparam int IW = $clog2(N);

  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [AW-1:0] STEP = AW'(P);
  localparam logic [AW-1:0] SIZE = AW'(N);

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  state_t          state;
  logic [IW-1:0]   fill_cnt;
  logic [IW-1:0]   out_cnt;
  logic [IW-1:0]   wr_addr;
  logic [IW-1:0]   rd_addr;
  logic            mode_q;
  logic [BITS-1:0] mem [N];

  logic            in_fire;
  logic            out_fire;
  logic            wr_mode;
  logic [IW-1:0]   wr_next;
  logic [IW-1:0]   rd_next;

  // One extra bit of headroom so a+P never wraps before the compare.
  function automatic logic [IW-1:0] perm_next(
    input logic [IW-1:0] a
  );
    logic [AW-1:0] s;
    s = {1'b0, a} + STEP;
    if (s >= SIZE) s = s - SIZE;
    return s[IW-1:0];
  endfunction

  function automatic logic [IW-1:0] seq_next(
    input logic [IW-1:0] a
  );
    return (a == LAST) ? '0 : a + ONE;
  endfunction

  assign in_ready  = rst_n && (state == FILL);
  assign out_valid = rst_n && (state == DRAIN);
  assign out_last  = out_valid && (out_cnt == LAST);
  assign busy      = rst_n &&
                     ((state == DRAIN) || (fill_cnt != '0));

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Beat 0 steers by the live mode, since the latch loads on that edge.
  assign wr_mode = (fill_cnt == '0) ? mode : mode_q;
  assign wr_next = wr_mode ? perm_next(wr_addr)
                           : seq_next(wr_addr);
  assign rd_next = mode_q ? seq_next(rd_addr)
                          : perm_next(rd_addr);

  assign out_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_addr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      out_cnt  <= '0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      mode_q   <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_fire) begin
            if (fill_cnt == '0) mode_q <= mode;
            if (fill_cnt == LAST) begin
              state    <= DRAIN;
              fill_cnt <= '0;
              wr_addr  <= '0;
            end else begin
              fill_cnt <= fill_cnt + ONE;
              wr_addr  <= wr_next;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_cnt == LAST) begin
              state   <= FILL;
              out_cnt <= '0;
              rd_addr <= '0;
            end else begin
              out_cnt <= out_cnt + ONE;
              rd_addr <= rd_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_prime_sequencer.sv
// Bench for interleaver_prime_sequencer: block-level permutation model,
// per-cycle output compare, and literal sequences that pin the model.
module tb_interleaver_prime_sequencer;

  localparam int BITS = 8;
  localparam int N    = 10;
  localparam int P    = 3;

  typedef logic [BITS-1:0] sym_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  sym_t in_data = '0;
  logic in_ready;
  logic out_valid;
  logic out_last;
  logic busy;
  sym_t out_data;

  int compared = 0;
  int mismatched = 0;
  int stall_pct = 0;

  int fwd_ref[N] = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7};
  int rev_ref[N] = '{0, 7, 4, 1, 8, 5, 2, 9, 6, 3};

  interleaver_prime_sequencer #(
    .BITS(BITS),
    .N(N),
    .P(P)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Block-level model: out[k] is the input whose beat lands at k.
  function automatic void model_block(input sym_t x[N],
                                      input logic m,
                                      output sym_t y[N]);
    for (int k = 0; k < N; k++) begin
      y[k] = '0;
      if (!m) begin
        y[k] = x[(P * k) % N];
      end else begin
        for (int i = 0; i < N; i++)
          if ((P * i) % N == k) y[k] = x[i];
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(99) >= stall_pct);
  end

  int   blk_cnt = 0;
  logic blk_mode = 1'b0;
  sym_t blk[N];
  sym_t y_m[N];
  sym_t exp_q[$];
  bit   last_q[$];
  sym_t cap[$];
  bit   held = 0;
  sym_t held_data = '0;
  bit   last_in = 0;

  always @(negedge clk) begin
    sym_t e;
    bit   l;
    if (!rst_n) begin
      blk_cnt = 0;
      exp_q.delete();
      last_q.delete();
      held = 0;
      last_in = 0;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_busy", busy, 0);
    end else begin
      if (last_in)
        check("valid_after_last_in", out_valid, 1);
      last_in = 0;
      check("ready_vs_valid", in_ready, !out_valid);
      check("busy", busy, out_valid || (blk_cnt != 0));
      if (out_valid && held)
        check("stall_hold", out_data, held_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_out");
        end else begin
          e = exp_q.pop_front();
          l = last_q.pop_front();
          check("out_data", out_data, e);
          check("out_last", out_last, l);
        end
        cap.push_back(out_data);
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) begin
        if (blk_cnt == 0) blk_mode = mode;
        blk[blk_cnt] = in_data;
        blk_cnt++;
        if (blk_cnt == N) begin
          model_block(blk, blk_mode, y_m);
          for (int k = 0; k < N; k++) begin
            exp_q.push_back(y_m[k]);
            last_q.push_back(k == N - 1);
          end
          blk_cnt = 0;
          last_in = 1;
        end
      end
    end
  end

  task automatic send_block(input sym_t x[N],
                            input logic m,
                            input int gap,
                            input bit toggle,
                            input bit keep);
    int i = 0;
    int budget = 0;
    bit hs;
    while (i < N && budget < 500) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data = x[i];
      if (i == 0 || !toggle) mode = m;
      else mode = 1'($urandom_range(1));
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      budget++;
    end
    if (!keep) in_valid = 1'b0;
    if (i < N) flag("send_timeout");
  endtask

  task automatic wait_cap(input int n);
    int budget = 0;
    while (cap.size() < n && budget < 1000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (cap.size() < n) flag("wait_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    sym_t x[N];
    sym_t xb[N];
    sym_t xc[N];
    sym_t y[N];
    sym_t ym[N];

    for (int k = 0; k < N; k++) x[k] = sym_t'(k);
    model_block(x, 1'b0, ym);
    for (int k = 0; k < N; k++)
      check("model_fwd", ym[k], fwd_ref[k]);
    model_block(x, 1'b1, ym);
    for (int k = 0; k < N; k++)
      check("model_rev", ym[k], rev_ref[k]);

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_busy", busy, 0);
    @(posedge clk);
    #1;

    stall_pct = 0;
    cap.delete();
    send_block(x, 1'b0, 0, 0, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("fwd_seq", cap[k], fwd_ref[k]);

    cap.delete();
    send_block(x, 1'b1, 0, 0, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("rev_seq", cap[k], rev_ref[k]);

    stall_pct = 40;
    cap.delete();
    send_block(x, 1'b0, 40, 0, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("fwd_stall_seq", cap[k], fwd_ref[k]);
    cap.delete();
    send_block(x, 1'b1, 40, 0, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("rev_stall_seq", cap[k], rev_ref[k]);

    stall_pct = 30;
    for (int k = 0; k < N; k++) xb[k] = sym_t'($urandom);
    cap.delete();
    send_block(xb, 1'b1, 30, 0, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++) y[k] = cap[k];
    cap.delete();
    send_block(y, 1'b0, 30, 0, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("fwd_of_rev", cap[k], xb[k]);

    stall_pct = 0;
    for (int k = 0; k < N; k++) xb[k] = sym_t'(20 + k);
    cap.delete();
    send_block(xb, 1'b0, 20, 1, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("toggle_fwd", cap[k], 20 + fwd_ref[k]);
    for (int k = 0; k < N; k++) xb[k] = sym_t'(30 + k);
    cap.delete();
    send_block(xb, 1'b1, 20, 1, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("toggle_rev", cap[k], 30 + rev_ref[k]);

    cap.delete();
    send_block(x, 1'b0, 0, 0, 0);
    wait_cap(4);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    cap.delete();
    for (int k = 0; k < N; k++) xb[k] = sym_t'(10 + k);
    send_block(xb, 1'b0, 0, 0, 0);
    wait_cap(N);
    for (int k = 0; k < N; k++)
      check("post_reset_seq", cap[k], 10 + fwd_ref[k]);
    check("no_residual", exp_q.size(), 0);

    stall_pct = 0;
    for (int k = 0; k < N; k++) begin
      xb[k] = sym_t'(40 + k);
      xc[k] = sym_t'(60 + k);
    end
    cap.delete();
    fork
      begin
        send_block(x, 1'b0, 0, 0, 1);
        send_block(xb, 1'b1, 0, 0, 1);
        send_block(xc, 1'b0, 0, 0, 0);
      end
      begin
        for (int c = 0; c < 6 * N; c++) begin
          @(negedge clk);
          check("b2b_in_ready", in_ready,
                ((c / N) % 2) == 0);
        end
      end
    join
    wait_cap(3 * N);
    for (int k = 0; k < N; k++)
      check("b2b_third", cap[2 * N + k], 60 + fwd_ref[k]);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/interleaver_prime_sequencer.md
INTERLEAVER_PRIME_SEQUENCER -- requirements
Module: interleaver_prime_sequencer

Interface
REQ-001 Parameter BITS, default 8, symbol width in bits.
REQ-002 Parameter N, default 10, symbols per block; N >= 2.
REQ-003 Parameter P, default 3, prime stride; 1 <= P < N and gcd(P,N) = 1.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous and active-low.
REQ-006 Port mode  input  1  0 = forward permutation, 1 = reverse permutation.
REQ-007 Port in_valid  input  1  input symbol valid.
REQ-008 Port in_ready  output  1  block accepts input symbol.
REQ-009 Port in_data  input  BITS  input symbol.
REQ-010 Port out_valid  output  1  output symbol valid.
REQ-011 Port out_ready  input  1  downstream accepts output symbol.
REQ-012 Port out_data  output  BITS  permuted output symbol.
REQ-013 Port out_last  output  1  high with the final (k = N-1) output symbol of a block.
REQ-014 Port busy  output  1  high whenever the block is not in FILL with fill count 0.

Function
REQ-015 Internal storage SHALL be an N-entry register array of BITS-bit words, single bank.
REQ-016 The FSM SHALL have two states: FILL (in_ready = 1, out_valid = 0) and DRAIN (in_ready = 0, out_valid = 1).
REQ-017 An input beat is accepted when in_valid && in_ready; an output beat completes when out_valid && out_ready.
REQ-018 mode SHALL be latched on acceptance of input beat 0 of each block; mode changes at any other time SHALL have no effect until the next block.
REQ-019 Forward mode: input beat i SHALL write mem[i]; output beat k SHALL read mem[(P*k) mod N].
REQ-020 Reverse mode: input beat i SHALL write mem[(P*i) mod N]; output beat k SHALL read mem[k].
REQ-021 Permuted addresses SHALL be generated incrementally without multiply or divide: start at 0, next = a+P, minus N if a+P >= N, computed in $clog2(N)+1 bits.
REQ-022 Sequential addresses SHALL count 0..N-1 and then return to 0.
REQ-023 FILL SHALL transition to DRAIN on the cycle after input beat N-1 is accepted, so out_valid rises exactly 1 cycle after the last input handshake.
REQ-024 DRAIN SHALL transition to FILL on the cycle after output beat N-1 completes, and all counters and addresses SHALL return to 0.
REQ-025 out_data SHALL be driven combinationally from mem at the current read address and SHALL hold stable while out_valid && !out_ready.
REQ-026 in_valid asserted during DRAIN SHALL be ignored, with no write and no count change.
REQ-027 out_ready low during DRAIN SHALL stall the read address and output count indefinitely without data loss.
REQ-028 Gaps in in_valid during FILL SHALL stall the write count without corrupting data.
REQ-029 Back-to-back blocks: in_ready SHALL reassert the cycle after the out_last handshake.
REQ-030 out_last SHALL equal out_valid && (output count == N-1).

Reset
REQ-031 While rst_n is low at a clock edge, the following SHALL happen on that edge:
- state goes to FILL;
- fill and output counters and both address registers go to 0;
- the latched mode goes to 0.
REQ-032 While rst_n is low, in_ready, out_valid, out_last and busy SHALL all be 0; in_ready SHALL be gated by rst_n.
REQ-033 Memory contents need no reset, and out_data is don't-care while out_valid = 0.
REQ-034 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial block, and the first block after reset SHALL start at beat 0.

Verification
REQ-035 With N=10, P=3 and mode=0, input 0..9 with out_ready=1 SHALL produce 0,3,6,9,2,5,8,1,4,7, with out_last on 7 and out_valid 1 cycle after the last input.
REQ-036 With mode=1, input 0..9 SHALL produce 0,7,4,1,8,5,2,9,6,3, and forward(reverse(x)) SHALL equal x over random data.
REQ-037 Random in_valid gaps and random out_ready stalls SHALL leave output sequences identical to REQ-035/036, with out_data stable during each stall.
REQ-038 Toggling mode at beats 1..9 of a block SHALL not alter that block, and the next block SHALL use the mode present at its beat 0.
REQ-039 Reset at output beat 4 followed by a new block of 10..19, mode=0, SHALL produce 10,13,16,19,12,15,18,11,14,17, with no residual data.
REQ-040 Three back-to-back blocks with in_valid and out_ready held at 1 SHALL show in_ready high for exactly 10 cycles then low for exactly 10 cycles, repeating.
